// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, 8N1 frame constants and divider helpers.
// Imported by the transmitter and intended for reuse by the matching receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned FRAME_BITS = 10;
  localparam logic        START_BIT  = 1'b0;
  localparam logic        STOP_BIT   = 1'b1;
  localparam logic        LINE_IDLE  = 1'b1;

  typedef logic [DATA_BITS-1:0] uart_byte_t;

  // Clocks per line bit; integer division truncates toward zero.
  function automatic int unsigned calc_baud_div(input int unsigned clk_freq,
                                                input int unsigned baud);
    return clk_freq / baud;
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tx_fifo.sv
// Synchronous transmit FIFO, DEPTH x 8, with registered full/empty and occupancy count.
// Full is judged on the registered state, so a push while full is refused even if a pop occurs.
module tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  uart_byte_t               data_i,
  input  logic                     pop_i,
  output uart_byte_t               rd_data_c_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  uart_byte_t         mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               full_q, empty_q;
  logic               push_ok, pop_ok;

  assign push_ok = push_i && !full_q && !rst_i;
  assign pop_ok  = pop_i && !empty_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == CNT_W'(DEPTH));
      empty_q  <= (count_d == '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign rd_data_c_o = mem_q[rd_ptr_q];
  assign full_o      = full_q;
  assign empty_o     = empty_q;
  assign count_o     = count_q;

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: byte FIFO feeding a start/data/stop shift FSM paced by a baud counter.
// TXD is registered and changes only on bit boundaries; back-to-back frames have no idle gap.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       full,
  output logic       overflow,
  output logic       busy,
  output logic       TXD
);

  localparam int unsigned BAUD_DIV = calc_baud_div(CLK_FREQ, BAUD);
  localparam int unsigned BAUD_W   = cnt_width(BAUD_DIV);
  localparam int unsigned BIT_W    = $clog2(DATA_BITS);
  localparam int unsigned CNT_W    = $clog2(FIFO_DEPTH) + 1;

  uart_state_e        state_q, state_d;
  logic [BAUD_W-1:0]  baud_cnt_q, baud_cnt_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  uart_byte_t         shift_q, shift_d;
  logic               txd_q, txd_d;
  logic               overflow_q, overflow_d;
  logic               pop_c;
  logic               baud_end;
  logic               bit_last;

  uart_byte_t         fifo_head;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;

  tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clock),
    .rst_i       (rst),
    .push_i      (wr_en),
    .data_i      (wr_data),
    .pop_i       (pop_c),
    .rd_data_c_o (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign baud_end = (baud_cnt_q == BAUD_W'(BAUD_DIV - 1));
  assign bit_last = (bit_cnt_q == BIT_W'(DATA_BITS - 1));

  // Next-state, line level and FIFO pop; TXD_d is chosen together with the transition it marks.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q + BAUD_W'(1);
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    txd_d      = txd_q;
    pop_c      = 1'b0;
    case (state_q)
      IDLE: begin
        baud_cnt_d = '0;
        txd_d      = LINE_IDLE;
        if (!fifo_empty) begin
          pop_c   = 1'b1;
          shift_d = fifo_head;
          state_d = START;
          txd_d   = START_BIT;
        end
      end
      START: begin
        if (baud_end) begin
          state_d    = DATA;
          baud_cnt_d = '0;
          bit_cnt_d  = '0;
          txd_d      = shift_q[0];
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_cnt_d = '0;
          if (bit_last) begin
            state_d = STOP;
            txd_d   = STOP_BIT;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
            txd_d     = shift_q[1];
          end
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_cnt_d = '0;
          if (!fifo_empty) begin
            pop_c   = 1'b1;
            shift_d = fifo_head;
            state_d = START;
            txd_d   = START_BIT;
          end else begin
            state_d = IDLE;
            txd_d   = LINE_IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        txd_d   = LINE_IDLE;
      end
    endcase
  end

  // A write is dropped whenever the FIFO was already full at the sampling edge.
  assign overflow_d = wr_en && fifo_full;

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      txd_q      <= LINE_IDLE;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      txd_q      <= txd_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy     = (state_q != IDLE) || (fifo_count != '0);
  assign full     = fifo_full;
  assign overflow = overflow_q;
  assign TXD      = txd_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: table-driven single frames plus hand sequences for
// back-to-back frames, FIFO fill/overflow, mid-frame reset and two other parameter sets.
module tb_uart_tx;

  localparam int BD_A = 15;    // 1000 / 64 truncated
  localparam int BD_B = 10;    // 1000 / 100
  localparam int BD_D = 5208;  // 50 MHz / 9600 truncated

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       rst_a, wr_en_a, full_a, ovf_a, busy_a, txd_a;
  logic [7:0] wr_data_a;
  logic       rst_b, wr_en_b, full_b, ovf_b, busy_b, txd_b;
  logic [7:0] wr_data_b;
  logic       rst_d, wr_en_d, full_d, ovf_d, busy_d, txd_d;
  logic [7:0] wr_data_d;

  uart_tx #(.CLK_FREQ(1000), .BAUD(64), .FIFO_DEPTH(16)) dut_a (
    .clock(clock), .rst(rst_a), .wr_en(wr_en_a), .wr_data(wr_data_a),
    .full(full_a), .overflow(ovf_a), .busy(busy_a), .TXD(txd_a));

  uart_tx #(.CLK_FREQ(1000), .BAUD(100), .FIFO_DEPTH(4)) dut_b (
    .clock(clock), .rst(rst_b), .wr_en(wr_en_b), .wr_data(wr_data_b),
    .full(full_b), .overflow(ovf_b), .busy(busy_b), .TXD(txd_b));

  uart_tx dut_d (
    .clock(clock), .rst(rst_d), .wr_en(wr_en_d), .wr_data(wr_data_d),
    .full(full_d), .overflow(ovf_d), .busy(busy_d), .TXD(txd_d));

  int   vec_cnt  = 0;
  int   miss_cnt = 0;
  int   sel      = 0;
  logic cur_txd, cur_busy;
  logic line_q[$];

  always_comb begin
    cur_txd  = (sel == 1) ? txd_b  : txd_a;
    cur_busy = (sel == 1) ? busy_b : busy_a;
  end

  typedef struct {
    logic [7:0] data;
    logic [9:0] line;  // line levels in time order, MSB first: start, d0..d7, stop
  } vec_t;

  vec_t tbl[3];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Samples the selected DUT line every cycle until nfr frames are collected, then grades each bit.
  task automatic run_frames(input string name, input int nfr, input logic [29:0] lines,
                            input int bd, output logic [7:0] dec);
    int n;
    int nlow;
    n = nfr * 10 * bd;
    while (line_q.size() < n) begin
      if (line_q.size() == n - 1) check({name, " busy_end"}, 32'(cur_busy), 32'd1);
      line_q.push_back(cur_txd);
      tick();
    end
    check({name, " busy_drop"}, 32'(cur_busy), 32'd0);
    check({name, " idle_line"}, 32'(cur_txd), 32'd1);
    for (int b = 0; b < nfr * 10; b++) begin
      nlow = 0;
      for (int s = 0; s < bd; s++) begin
        if (line_q[b * bd + s] == 1'b0) nlow++;
      end
      check($sformatf("%s bit%0d", name, b), 32'(nlow), lines[29 - b] ? 32'd0 : 32'(bd));
    end
    for (int i = 0; i < 8; i++) dec[i] = line_q[(1 + i) * bd + bd / 2];
    line_q.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] dec;
    int         n;

    tbl[0] = '{data: 8'h55, line: 10'b0101010101};
    tbl[1] = '{data: 8'h3C, line: 10'b0001111001};
    tbl[2] = '{data: 8'hA5, line: 10'b0101001011};

    rst_a = 1'b1; wr_en_a = 1'b0; wr_data_a = 8'h00;
    rst_b = 1'b1; wr_en_b = 1'b0; wr_data_b = 8'h00;
    rst_d = 1'b1; wr_en_d = 1'b0; wr_data_d = 8'h00;
    tick();
    tick();
    check("rst txd_a", 32'(txd_a), 32'd1);
    check("rst busy_a", 32'(busy_a), 32'd0);
    check("rst full_a", 32'(full_a), 32'd0);
    check("rst ovf_a", 32'(ovf_a), 32'd0);
    check("rst txd_b", 32'(txd_b), 32'd1);
    check("rst full_b", 32'(full_b), 32'd0);
    check("rst ovf_b", 32'(ovf_b), 32'd0);
    check("rst txd_d", 32'(txd_d), 32'd1);
    check("rst full_d", 32'(full_d), 32'd0);
    check("rst ovf_d", 32'(ovf_d), 32'd0);
    rst_a = 1'b0; rst_b = 1'b0; rst_d = 1'b0;
    tick();

    // Single frames from the table on the BAUD_DIV=15 instance.
    sel = 0;
    for (int i = 0; i < 3; i++) begin
      wr_en_a = 1'b1; wr_data_a = tbl[i].data;
      tick();
      wr_en_a = 1'b0;
      check($sformatf("tbl%0d lat1", i), 32'(txd_a), 32'd1);
      tick();
      check($sformatf("tbl%0d lat2", i), 32'(txd_a), 32'd0);
      run_frames($sformatf("tbl%0d", i), 1, {tbl[i].line, 20'b0}, BD_A, dec);
      check($sformatf("tbl%0d decode", i), 32'(dec), 32'(tbl[i].data));
      repeat (3) tick();
    end

    // Three writes on consecutive cycles: frames must abut with no idle gap.
    wr_en_a = 1'b1; wr_data_a = 8'h00;
    tick();
    check("b2b lat1", 32'(txd_a), 32'd1);
    wr_data_a = 8'hFF;
    tick();
    check("b2b lat2", 32'(txd_a), 32'd0);
    line_q.push_back(txd_a);
    wr_data_a = 8'hA5;
    tick();
    wr_en_a = 1'b0;
    run_frames("b2b", 3, {10'b0000000001, 10'b0111111111, 10'b0101001011}, BD_A, dec);
    check("b2b decode0", 32'(dec), 32'h00);
    repeat (3) tick();

    // Fill: 17 writes while idle, first byte popped, then overflow on further writes.
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    tick();
    for (int i = 0; i < 17; i++) begin
      wr_en_a = 1'b1; wr_data_a = 8'(8'h10 + i);
      tick();
      if (i == 1)  check("fill first_popped", 32'(txd_a), 32'd0);
      if (i == 15) check("fill not_full_yet", 32'(full_a), 32'd0);
    end
    check("fill full", 32'(full_a), 32'd1);
    check("fill count16", 32'(dut_a.u_fifo.count_o), 32'd16);
    check("fill no_ovf", 32'(ovf_a), 32'd0);
    wr_data_a = 8'h99;
    tick();
    wr_en_a = 1'b0;
    check("ovf pulse", 32'(ovf_a), 32'd1);
    check("ovf count16", 32'(dut_a.u_fifo.count_o), 32'd16);
    tick();
    check("ovf one_cycle", 32'(ovf_a), 32'd0);
    repeat (132) tick();
    check("stopend stop_level", 32'(txd_a), 32'd1);
    check("stopend still_full", 32'(full_a), 32'd1);
    wr_en_a = 1'b1; wr_data_a = 8'h77;
    tick();
    wr_en_a = 1'b0;
    check("stopend ovf", 32'(ovf_a), 32'd1);
    check("stopend count15", 32'(dut_a.u_fifo.count_o), 32'd15);
    check("stopend not_full", 32'(full_a), 32'd0);
    check("stopend no_gap", 32'(txd_a), 32'd0);
    tick();
    check("stopend ovf_clear", 32'(ovf_a), 32'd0);

    // Reset during data bit 3 with 5 bytes queued.
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) begin
      wr_en_a = 1'b1; wr_data_a = 8'(8'h31 + i);
      tick();
    end
    wr_en_a = 1'b0;
    check("midrst queued5", 32'(dut_a.u_fifo.count_o), 32'd5);
    repeat (63) tick();
    check("midrst bit3_level", 32'(txd_a), 32'd0);
    rst_a = 1'b1; wr_en_a = 1'b1; wr_data_a = 8'hEE;
    tick();
    check("midrst txd", 32'(txd_a), 32'd1);
    check("midrst busy", 32'(busy_a), 32'd0);
    check("midrst full", 32'(full_a), 32'd0);
    check("midrst ovf", 32'(ovf_a), 32'd0);
    check("midrst count0", 32'(dut_a.u_fifo.count_o), 32'd0);
    rst_a = 1'b0; wr_en_a = 1'b0;
    n = 0;
    repeat (300) begin
      if (txd_a !== 1'b1) n++;
      tick();
    end
    check("midrst no_frame", 32'(n), 32'd0);
    check("midrst still_idle", 32'(busy_a), 32'd0);

    // BAUD_DIV=10 instance sending 0xC3.
    sel = 1;
    wr_en_b = 1'b1; wr_data_b = 8'hC3;
    tick();
    wr_en_b = 1'b0;
    check("c3 lat1", 32'(txd_b), 32'd1);
    tick();
    check("c3 lat2", 32'(txd_b), 32'd0);
    run_frames("c3", 1, {10'b0110000111, 20'b0}, BD_B, dec);
    check("c3 decode", 32'(dec), 32'hC3);
    sel = 0;

    // Default parameters: 0x55, start bit and first data bit each 5208 clocks.
    wr_en_d = 1'b1; wr_data_d = 8'h55;
    tick();
    wr_en_d = 1'b0;
    check("dflt lat1", 32'(txd_d), 32'd1);
    tick();
    check("dflt lat2", 32'(txd_d), 32'd0);
    check("dflt busy", 32'(busy_d), 32'd1);
    n = 0;
    while (txd_d === 1'b0 && n < 6000) begin
      n++;
      tick();
    end
    check("dflt start_len", 32'(n), 32'(BD_D));
    n = 0;
    while (txd_d === 1'b1 && n < 6000) begin
      n++;
      tick();
    end
    check("dflt bit0_len", 32'(n), 32'(BD_D));
    check("dflt bit1_level", 32'(txd_d), 32'd0);
    rst_d = 1'b1;
    tick();
    rst_d = 1'b0;
    check("dflt rst_txd", 32'(txd_d), 32'd1);
    check("dflt rst_busy", 32'(busy_d), 32'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
